smith_waterman: RTL and testbench

SMITH_WATERMAN -- requirements
Module: smith_waterman

---
 rtl/sw_pkg.sv | 36 +++
 rtl/sw_cell.sv | 55 +++++
 rtl/smith_waterman.sv | 213 +++++++++++++++++++++
 tb/tb_smith_waterman.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman local-alignment engine:
// sizes, character encoding, the controller state type and a floor-at-zero
// subtract helper used by the cell datapath.
package sw_pkg;

  localparam int PE_ARRAY_SIZE     = 64;
  localparam int PE_ARRAY_SIZE_LOG = 6;
  localparam int V_E_F_BIT         = 16;
  localparam int T_MAX             = 1024;
  localparam int T_IDX_BIT         = 10;
  localparam int T_LEN_BIT         = 11;

  localparam logic [1:0] CHAR_A = 2'd0;
  localparam logic [1:0] CHAR_C = 2'd1;
  localparam logic [1:0] CHAR_G = 2'd2;
  localparam logic [1:0] CHAR_T = 2'd3;

  localparam logic [6:0] S_VALID_FULL = 7'd127;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_T,
    REQ_S,
    CALC,
    DONE
  } sw_state_e;

  // Unsigned subtract of a 4-bit penalty that clamps at zero instead of wrapping.
  function automatic logic [V_E_F_BIT-1:0] subFloor(input logic [V_E_F_BIT-1:0] a,
                                                    input logic [3:0] b);
    logic [V_E_F_BIT-1:0] bWide;
    bWide = {{(V_E_F_BIT-4){1'b0}}, b};
    subFloor = (a > bWide) ? (a - bWide) : '0;
  endfunction

endpackage

// File: rtl/sw_cell.sv
// Combinational affine-gap update for one alignment cell (H, E, F).
// SW_SATURATE_EN: when defined, the diagonal match addition saturates at the
// top of the score range; otherwise it wraps. Subtractions always clamp at 0.
module sw_cell
  import sw_pkg::*;
(
  input  logic [1:0]           s_char_i,
  input  logic [1:0]           t_char_i,
  input  logic [V_E_F_BIT-1:0] h_diag_i,
  input  logic [V_E_F_BIT-1:0] h_up_i,
  input  logic [V_E_F_BIT-1:0] f_up_i,
  input  logic [V_E_F_BIT-1:0] h_left_i,
  input  logic [V_E_F_BIT-1:0] e_left_i,
  input  logic [3:0]           match_i,
  input  logic [3:0]           mismatch_i,
  input  logic [3:0]           alpha_i,
  input  logic [3:0]           beta_i,
  output logic [V_E_F_BIT-1:0] h_o,
  output logic [V_E_F_BIT-1:0] e_o,
  output logic [V_E_F_BIT-1:0] f_o
);

  function automatic logic [V_E_F_BIT-1:0] addScore(input logic [V_E_F_BIT-1:0] a,
                                                    input logic [3:0] b);
`ifdef SW_SATURATE_EN
    logic [V_E_F_BIT:0] sum;
    sum = {1'b0, a} + {{(V_E_F_BIT-3){1'b0}}, b};
    addScore = sum[V_E_F_BIT] ? '1 : sum[V_E_F_BIT-1:0];
`else
    addScore = a + {{(V_E_F_BIT-4){1'b0}}, b};
`endif
  endfunction

  logic [V_E_F_BIT-1:0] eOpen, eExt, fOpen, fExt, diagScore, hMax;

  // Gap scores from the left (E) and from above (F), then the best of diagonal, E, F; unsigned so floor 0 is implicit.
  always_comb begin
    eOpen = subFloor(h_left_i, alpha_i);
    eExt  = subFloor(e_left_i, beta_i);
    e_o   = (eOpen > eExt) ? eOpen : eExt;
    fOpen = subFloor(h_up_i, alpha_i);
    fExt  = subFloor(f_up_i, beta_i);
    f_o   = (fOpen > fExt) ? fOpen : fExt;
    if (s_char_i == t_char_i) begin
      diagScore = addScore(h_diag_i, match_i);
    end else begin
      diagScore = subFloor(h_diag_i, mismatch_i);
    end
    hMax = diagScore;
    if (e_o > hMax) hMax = e_o;
    if (f_o > hMax) hMax = f_o;
    h_o = hMax;
  end

endmodule

// File: rtl/smith_waterman.sv
// Smith-Waterman local-alignment engine. Target t is loaded into an internal
// store; query s is streamed in 64-char chunks and scored one cell per cycle,
// walking each s character across the whole of t. The previous row's H and F
// live in row memories so the matrix continues seamlessly across chunks.
module smith_waterman
  import sw_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_set_t,
  input  logic                 i_start_cal,
  output logic                 o_busy,
  output logic [V_E_F_BIT-1:0] o_result,
  output logic                 o_valid,
  output logic                 o_request_s,
  input  logic [17:0]          i_t,
  input  logic [127:0]         i_s,
  input  logic [6:0]           i_s_valid,
  input  logic [3:0]           i_match,
  input  logic [3:0]           i_mismatch,
  input  logic [3:0]           i_minusAlpha,
  input  logic [3:0]           i_minusBeta
);

  sw_state_e                   state_q;
  logic                        busy_q, valid_q, reqS_q;
  logic [V_E_F_BIT-1:0]        result_q, maxH_q, hDiag_q, hLeft_q, eLeft_q;
  logic [T_LEN_BIT-1:0]        tLen_q;
  logic [1:0]                  tMem_q [T_MAX];
  logic [V_E_F_BIT-1:0]        hRow_q [T_MAX];
  logic [V_E_F_BIT-1:0]        fRow_q [T_MAX];
  logic [3:0]                  match_q, mismatch_q, alpha_q, beta_q;
  logic [127:0]                sBuf_q;
  logic [6:0]                  sCnt_q;
  logic                        sLast_q;
  logic [PE_ARRAY_SIZE_LOG-1:0] sIdx_q;
  logic [T_IDX_BIT-1:0]        j_q;
  logic                        firstRow_q;

  logic [2:0]                  tWordCnt;
  logic [T_LEN_BIT-1:0]        tRoom, tAdd;
  logic [T_LEN_BIT-1:0]        wrSum [7];
  logic                        wrEn  [7];
  logic [T_IDX_BIT-1:0]        wrIdx [7];

  logic [1:0]                  sChar, tChar;
  logic [V_E_F_BIT-1:0]        hUp, fUp, hDiag, hLeft, eLeft;
  logic [V_E_F_BIT-1:0]        hCell, eCell, fCell, cellMax;
  logic                        rowEnd, lastChar, chunkDone;

  assign tWordCnt = i_t[16:14];

  // Work out where each char of an incoming t word lands and how many fit before the store is full.
  always_comb begin
    tRoom = T_LEN_BIT'(T_MAX) - tLen_q;
    tAdd  = (T_LEN_BIT'(tWordCnt) < tRoom) ? T_LEN_BIT'(tWordCnt) : tRoom;
    for (int k = 0; k < 7; k++) begin
      wrSum[k] = tLen_q + T_LEN_BIT'(k);
      wrEn[k]  = (3'(k) < tWordCnt) && (wrSum[k] < T_LEN_BIT'(T_MAX));
      wrIdx[k] = wrSum[k][T_IDX_BIT-1:0];
    end
  end

  // Cell operands; the first row and first column see zero boundary values.
  always_comb begin
    sChar     = sBuf_q[{sIdx_q, 1'b0} +: 2];
    tChar     = tMem_q[j_q];
    hUp       = firstRow_q ? '0 : hRow_q[j_q];
    fUp       = firstRow_q ? '0 : fRow_q[j_q];
    hDiag     = (j_q == '0) ? '0 : hDiag_q;
    hLeft     = (j_q == '0) ? '0 : hLeft_q;
    eLeft     = (j_q == '0) ? '0 : eLeft_q;
    cellMax   = (hCell > maxH_q) ? hCell : maxH_q;
    rowEnd    = ({1'b0, j_q} == (tLen_q - T_LEN_BIT'(1)));
    lastChar  = ({1'b0, sIdx_q} == (sCnt_q - 7'd1));
    chunkDone = (tLen_q == '0) || (rowEnd && lastChar);
  end

  sw_cell u_cell (
    .s_char_i   (sChar),
    .t_char_i   (tChar),
    .h_diag_i   (hDiag),
    .h_up_i     (hUp),
    .f_up_i     (fUp),
    .h_left_i   (hLeft),
    .e_left_i   (eLeft),
    .match_i    (match_q),
    .mismatch_i (mismatch_q),
    .alpha_i    (alpha_q),
    .beta_i     (beta_q),
    .h_o        (hCell),
    .e_o        (eCell),
    .f_o        (fCell)
  );

  // Storage for t and the previous-row H/F; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (state_q == LOAD_T) begin
      for (int k = 0; k < 7; k++) begin
        if (wrEn[k]) tMem_q[wrIdx[k]] <= i_t[2*k +: 2];
      end
    end
    if ((state_q == CALC) && (tLen_q != '0)) begin
      hRow_q[j_q] <= hCell;
      fRow_q[j_q] <= fCell;
    end
  end

  // Controller: t loading, s chunk handshake, cell walk and result publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      reqS_q     <= 1'b0;
      result_q   <= '0;
      tLen_q     <= '0;
      match_q    <= '0;
      mismatch_q <= '0;
      alpha_q    <= '0;
      beta_q     <= '0;
      sBuf_q     <= '0;
      sCnt_q     <= '0;
      sLast_q    <= 1'b0;
      sIdx_q     <= '0;
      j_q        <= '0;
      firstRow_q <= 1'b1;
      maxH_q     <= '0;
      hDiag_q    <= '0;
      hLeft_q    <= '0;
      eLeft_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_set_t) begin
            state_q <= LOAD_T;
            busy_q  <= 1'b1;
            tLen_q  <= '0;
          end else if (i_start_cal) begin
            state_q    <= REQ_S;
            busy_q     <= 1'b1;
            reqS_q     <= 1'b1;
            match_q    <= i_match;
            mismatch_q <= i_mismatch;
            alpha_q    <= i_minusAlpha;
            beta_q     <= i_minusBeta;
            firstRow_q <= 1'b1;
            maxH_q     <= '0;
          end
        end
        LOAD_T: begin
          if (tWordCnt != 3'd0) tLen_q <= tLen_q + tAdd;
          if (i_t[17]) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        REQ_S: begin
          if (i_s_valid != 7'd0) begin
            sBuf_q  <= i_s;
            sCnt_q  <= (i_s_valid > 7'(PE_ARRAY_SIZE)) ? 7'(PE_ARRAY_SIZE) : i_s_valid;
            sLast_q <= (i_s_valid != S_VALID_FULL);
            sIdx_q  <= '0;
            j_q     <= '0;
            reqS_q  <= 1'b0;
            state_q <= CALC;
          end
        end
        CALC: begin
          if (tLen_q != '0) begin
            hDiag_q <= hUp;
            hLeft_q <= hCell;
            eLeft_q <= eCell;
            maxH_q  <= cellMax;
            if (rowEnd) begin
              j_q        <= '0;
              firstRow_q <= 1'b0;
              if (!lastChar) sIdx_q <= sIdx_q + PE_ARRAY_SIZE_LOG'(1);
            end else begin
              j_q <= j_q + T_IDX_BIT'(1);
            end
          end
          if (chunkDone) begin
            if (sLast_q) begin
              result_q <= (tLen_q == '0) ? maxH_q : cellMax;
              valid_q  <= 1'b1;
              state_q  <= DONE;
            end else begin
              reqS_q  <= 1'b1;
              state_q <= REQ_S;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          reqS_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_busy      = busy_q;
  assign o_valid     = valid_q;
  assign o_request_s = reqS_q;
  assign o_result    = result_q;

endmodule

// File: tb/tb_smith_waterman.sv
// Directed bench for smith_waterman: loads targets, streams queries in
// chunks, and checks the scored result against a scoreboard queue.
module tb_smith_waterman;
  import sw_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_set_t, i_start_cal;
  logic         o_busy, o_valid, o_request_s;
  logic [15:0]  o_result;
  logic [17:0]  i_t;
  logic [127:0] i_s;
  logic [6:0]   i_s_valid;
  logic [3:0]   i_match, i_mismatch, i_minusAlpha, i_minusBeta;

  int          vecCount = 0;
  int          missCount = 0;
  logic [31:0] expQ[$];
  byte         tSeq[$];
  byte         sSeq[$];

  always #5 clk = ~clk;

  smith_waterman dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_set_t      (i_set_t),
    .i_start_cal  (i_start_cal),
    .o_busy       (o_busy),
    .o_result     (o_result),
    .o_valid      (o_valid),
    .o_request_s  (o_request_s),
    .i_t          (i_t),
    .i_s          (i_s),
    .i_s_valid    (i_s_valid),
    .i_match      (i_match),
    .i_mismatch   (i_mismatch),
    .i_minusAlpha (i_minusAlpha),
    .i_minusBeta  (i_minusBeta)
  );

  // Hard stop so the run can never hang.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic byte enc(input byte c);
    case (c)
      "A": enc = byte'(CHAR_A);
      "C": enc = byte'(CHAR_C);
      "G": enc = byte'(CHAR_G);
      default: enc = byte'(CHAR_T);
    endcase
  endfunction

  function automatic int floor0(input int v);
    floor0 = (v < 0) ? 0 : v;
  endfunction

  function automatic int max2(input int a, input int b);
    max2 = (a > b) ? a : b;
  endfunction

  // Reference score computed directly from the alignment recurrence.
  function automatic int refScore(input int m, input int mm, input int a, input int b);
    int hRow[0:64];
    int fRow[0:64];
    int best, diag, hl, el, up, fu, e, f, d, h;
    byte sc, tc;
    best = 0;
    for (int j = 0; j <= 64; j++) begin hRow[j] = 0; fRow[j] = 0; end
    for (int i = 0; i < sSeq.size(); i++) begin
      diag = 0; hl = 0; el = 0;
      sc = sSeq[i];
      for (int j = 1; j <= tSeq.size(); j++) begin
        tc = tSeq[j-1];
        up = hRow[j];
        fu = fRow[j];
        e = max2(floor0(hl - a), floor0(el - b));
        f = max2(floor0(up - a), floor0(fu - b));
        d = (sc == tc) ? diag + m : floor0(diag - mm);
        h = max2(max2(0, d), max2(e, f));
        diag = up;
        hRow[j] = h; fRow[j] = f;
        hl = h; el = e;
        best = max2(best, h);
      end
    end
    refScore = best;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    assert (observed === expected) else begin
      missCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic setS(input string str);
    sSeq.delete();
    for (int i = 0; i < str.len(); i++) sSeq.push_back(enc(str[i]));
  endtask

  task automatic loadTSeq();
    int n, pos, cnt;
    logic [17:0] w;
    byte c;
    i_set_t = 1'b1;
    step();
    i_set_t = 1'b0;
    checkOutput("busy_on_set_t", 32'(o_busy), 32'd1);
    n = tSeq.size();
    pos = 0;
    do begin
      cnt = (n - pos > 7) ? 7 : n - pos;
      w = '0;
      for (int k = 0; k < cnt; k++) begin
        c = tSeq[pos+k];
        w[2*k +: 2] = c[1:0];
      end
      w[16:14] = 3'(cnt);
      pos += cnt;
      w[17] = (pos >= n);
      i_t = w;
      step();
    end while (pos < n);
    i_t = '0;
    checkOutput("busy_after_last_t", 32'(o_busy), 32'd0);
  endtask

  task automatic loadT(input string str);
    tSeq.delete();
    for (int i = 0; i < str.len(); i++) tSeq.push_back(enc(str[i]));
    loadTSeq();
  endtask

  // Start a calculation, serve every chunk request, then score the result.
  task automatic applyStimulus(input int expHs, input logic [31:0] expected);
    int pos, hs, n;
    bit done, got;
    logic [127:0] chunk;
    byte c;
    expQ.push_back(expected);
    i_start_cal = 1'b1;
    step();
    i_start_cal = 1'b0;
    checkOutput("busy_on_start", 32'(o_busy), 32'd1);
    pos = 0; hs = 0; done = 1'b0;
    while (!done) begin
      got = 1'b0;
      for (int w = 0; w < 3000 && !got; w++) begin
        if (o_request_s) got = 1'b1;
        else step();
      end
      if (!got) begin
        checkOutput("request_timeout", 32'd0, 32'd1);
        void'(expQ.pop_front());
        return;
      end
      n = sSeq.size() - pos;
      chunk = '0;
      if (n > 64) begin
        n = 64;
        i_s_valid = 7'd127;
      end else begin
        i_s_valid = 7'(n);
        done = 1'b1;
      end
      for (int k = 0; k < n; k++) begin
        c = sSeq[pos+k];
        chunk[2*k +: 2] = c[1:0];
      end
      i_s = chunk;
      pos += n;
      step();
      i_s_valid = '0;
      hs++;
      checkOutput("request_low_after_capture", 32'(o_request_s), 32'd0);
    end
    got = 1'b0;
    for (int w = 0; w < 5000 && !got; w++) begin
      if (o_valid) got = 1'b1;
      else step();
    end
    if (!got) begin
      checkOutput("valid_timeout", 32'd0, 32'd1);
      void'(expQ.pop_front());
      return;
    end
    checkOutput("busy_with_valid", 32'(o_busy), 32'd1);
    checkOutput("result", 32'(o_result), expQ.pop_front());
    checkOutput("handshakes", 32'(hs), 32'(expHs));
    step();
    checkOutput("valid_one_cycle", 32'(o_valid), 32'd0);
    checkOutput("busy_falls", 32'(o_busy), 32'd0);
  endtask

  task automatic build100();
    sSeq.delete();
    for (int i = 0; i < 100; i++) sSeq.push_back((i >= 62 && i <= 65) ? byte'(i - 62) : byte'(0));
  endtask

  initial begin
    int expScore, len;
    bit got;
    rst_n = 1'b0;
    i_set_t = 1'b0; i_start_cal = 1'b0;
    i_t = '0; i_s = '0; i_s_valid = '0;
    i_match = 4'd2; i_mismatch = 4'd1; i_minusAlpha = 4'd2; i_minusBeta = 4'd1;
    repeat (3) step();
    checkOutput("reset_busy", 32'(o_busy), 32'd0);
    checkOutput("reset_valid", 32'(o_valid), 32'd0);
    checkOutput("reset_request", 32'(o_request_s), 32'd0);
    checkOutput("reset_result", 32'(o_result), 32'd0);
    rst_n = 1'b1;
    step();

    $display("[TB] exact match ACGT/ACGT");
    loadT("ACGT"); setS("ACGT"); applyStimulus(1, 32'd8);
    repeat (3) step();
    checkOutput("result_hold", 32'(o_result), 32'd8);

    $display("[TB] no match AAAA/TTTT");
    loadT("AAAA"); setS("TTTT"); applyStimulus(1, 32'd0);

    $display("[TB] single gap AAGG/AACGG");
    loadT("AAGG"); setS("AACGG"); applyStimulus(1, 32'd6);

    $display("[TB] two-chunk query across boundary");
    loadT("ACGT"); build100(); applyStimulus(2, 32'd8);

    $display("[TB] set_t priority, busy ignore, empty target");
    i_set_t = 1'b1; i_start_cal = 1'b1;
    step();
    i_set_t = 1'b0; i_start_cal = 1'b0;
    checkOutput("both_high_busy", 32'(o_busy), 32'd1);
    i_start_cal = 1'b1;
    step();
    i_start_cal = 1'b0;
    checkOutput("set_t_wins", 32'(o_request_s), 32'd0);
    i_t = 18'h20000;
    step();
    i_t = '0;
    checkOutput("empty_t_done", 32'(o_busy), 32'd0);
    checkOutput("start_ignored_busy", 32'(o_request_s), 32'd0);
    tSeq.delete();
    setS("ACGT"); applyStimulus(1, 32'd0);

    $display("[TB] random target/query against reference");
    i_match = 4'($urandom_range(1, 4));
    i_mismatch = 4'($urandom_range(0, 4));
    i_minusAlpha = 4'($urandom_range(0, 4));
    i_minusBeta = 4'($urandom_range(0, 3));
    tSeq.delete();
    len = $urandom_range(5, 12);
    for (int i = 0; i < len; i++) tSeq.push_back(byte'($urandom_range(0, 3)));
    loadTSeq();
    sSeq.delete();
    len = $urandom_range(70, 90);
    for (int i = 0; i < len; i++) sSeq.push_back(byte'($urandom_range(0, 3)));
    expScore = refScore(int'(i_match), int'(i_mismatch), int'(i_minusAlpha), int'(i_minusBeta));
    applyStimulus(2, 32'(expScore));

    $display("[TB] reset during calculation");
    i_match = 4'd2; i_mismatch = 4'd1; i_minusAlpha = 4'd2; i_minusBeta = 4'd1;
    loadT("ACGT");
    i_start_cal = 1'b1;
    step();
    i_start_cal = 1'b0;
    got = 1'b0;
    for (int w = 0; w < 100 && !got; w++) begin
      if (o_request_s) got = 1'b1;
      else step();
    end
    checkOutput("mid_reset_request", 32'(got), 32'd1);
    i_s = '0; i_s_valid = 7'd127;
    step();
    i_s_valid = '0;
    repeat (5) step();
    rst_n = 1'b0;
    step();
    checkOutput("mid_reset_busy", 32'(o_busy), 32'd0);
    checkOutput("mid_reset_valid", 32'(o_valid), 32'd0);
    checkOutput("mid_reset_request_low", 32'(o_request_s), 32'd0);
    checkOutput("mid_reset_result", 32'(o_result), 32'd0);
    rst_n = 1'b1;
    step();
    loadT("ACGT"); setS("ACGT"); applyStimulus(1, 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
